// File: rtl/pattern_det_pkg.sv
// pattern_det_pkg: elaboration-time helpers for the serial pattern detector
package pattern_det_pkg;
  localparam int MAX_PAT_W = 32;
  function automatic int pd_state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
  function automatic int pd_next_state(input logic [MAX_PAT_W-1:0] pattern, input int pat_w,
                                       input int k, input logic b, input logic overlap);
    logic [MAX_PAT_W:0] s;
    logic ok;
    int m;
    int res;
    m = k;
    if (k >= pat_w) begin
      m = 0;
      if (overlap)
        for (int j = 1; j < pat_w; j++) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++) if (pattern[j-1-i] != pattern[pat_w-1-i]) ok = 1'b0;
          if (ok) m = j;
        end
    end
    s = '0;
    for (int i = 0; i < m; i++) s[i] = pattern[pat_w-1-i];
    s[m] = b;
    res = 0;
    // longest prefix of the pattern that ends the matched bits plus the new bit
    for (int j = 1; j <= m + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) if (s[m+1-j+i] != pattern[pat_w-1-i]) ok = 1'b0;
      if (ok) res = j;
    end
    return res;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and all-ones flag
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
      sat <= &(cnt + CNT_W'(1));
    end
endmodule

// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector: parametrised Moore serial-pattern detector with saturating match counter
module moore_pattern_detector
  import pattern_det_pkg::*;
#(
  parameter int             PAT_W            = 3,
  parameter logic [PAT_W-1:0] PATTERN        = 3'b101,
  parameter bit             OVERLAP          = 1'b1,
  parameter int             CNT_W            = 8,
  parameter string          FSM_ENCODING_VAL = "one_hot"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  input  logic             clear,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int SW = pd_state_w(PAT_W);
  localparam int NST = 1 << SW;
  localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
  localparam logic [SW-1:0] S0 = '0;
  localparam logic [SW-1:0] S_FULL = SW'(PAT_W);
  if (PAT_W < 1 || PAT_W > MAX_PAT_W || CNT_W < 1 || FSM_ENCODING_VAL == "") begin : g_bad_param
    $error("moore_pattern_detector: illegal parameter set");
  end
  function automatic logic [NST*2*SW-1:0] build_tab();
    logic [NST*2*SW-1:0] t;
    t = '0;
    for (int k = 0; k <= PAT_W; k++)
      for (int b = 0; b < 2; b++)
        t[(k*2+b)*SW +: SW] = SW'(pd_next_state(PAT_EXT, PAT_W, k, b[0], OVERLAP));
    return t;
  endfunction
  localparam logic [NST*2*SW-1:0] NS_TAB = build_tab();
  (* fsm_encoding = FSM_ENCODING_VAL *) logic [SW-1:0] cs;
  logic [SW-1:0] ns;
  logic hit_q;
  assign ns = NS_TAB[SW*int'({cs, sin}) +: SW];
  // a pending hit is consumed only on an enabled edge, so disabled cycles neither pulse nor count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs    <= S0;
      hit_q <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      cs    <= S0;
      hit_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= hit_q & en;
      if (en) begin
        cs    <= ns;
        hit_q <= ns == S_FULL;
      end
    end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit_q & en),
    .clr  (clear),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );
endmodule
